// File: rtl/pipe_rca_addsub_if.sv
// Operand/result handshake bundle for pipe_rca_addsub.
// The slave modport is the adder's view; master is the producer/consumer view.
interface pipe_rca_addsub_if #(
   parameter int WIDTH = 8
);
   logic             IN_VALID;
   logic             IN_READY;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             CIN;
   logic             SUB;
   logic             OUT_VALID;
   logic             OUT_READY;
   logic [WIDTH-1:0] SUM;
   logic             COUT;
   logic             OVF;

   modport master (
      output IN_VALID, A, B, CIN, SUB, OUT_READY,
      input  IN_READY, OUT_VALID, SUM, COUT, OVF
   );

   modport slave (
      input  IN_VALID, A, B, CIN, SUB, OUT_READY,
      output IN_READY, OUT_VALID, SUM, COUT, OVF
   );
endinterface

// File: rtl/pipe_rca_addsub.sv
// Pipelined ripple-carry adder/subtractor, STAGES slices of WIDTH/STAGES bits, valid/ready.
// Optional macro PIPE_RCA_SAT_EN adds unsigned saturation of SUM in the final stage.
module pipe_rca_addsub #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input logic               CLK,
   input logic               RST,
   pipe_rca_addsub_if.slave  bus
);
   localparam int S = WIDTH / STAGES;

   logic             adv;
   logic             out_valid;
   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;

   // Subtract folds into the same chain as A + ~B + ~CIN.
   assign b_eff   = bus.SUB ? ~bus.B   : bus.B;
   assign cin_eff = bus.SUB ? ~bus.CIN : bus.CIN;

   assign out_valid    = stg[STAGES-1].v_reg;
   assign adv          = ~out_valid | bus.OUT_READY;
   assign bus.IN_READY = adv;

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : stg
         // Each stage sees only the operand bits not yet consumed, lowest slice at bit 0.
         localparam int REM = WIDTH - gi * S;
         localparam int HI  = (gi + 1) * S;

         logic [REM-1:0] a_in;
         logic [REM-1:0] b_in;
         logic           c_in;
         logic           v_in;
         logic [S:0]     slice;
         logic [HI-1:0]  sum_raw;
         logic [HI-1:0]  sum_next;
         logic [HI-1:0]  sum_reg;
         logic           c_reg;
         logic           v_reg;
`ifdef PIPE_RCA_SAT_EN
         logic           sub_in;
`endif

         if (gi == 0) begin : g_src
            assign a_in    = bus.A;
            assign b_in    = b_eff;
            assign c_in    = cin_eff;
            assign v_in    = bus.IN_VALID;
            assign sum_raw = slice[S-1:0];
`ifdef PIPE_RCA_SAT_EN
            assign sub_in  = bus.SUB;
`endif
         end else begin : g_src
            assign a_in    = stg[gi-1].g_fwd.a_reg;
            assign b_in    = stg[gi-1].g_fwd.b_reg;
            assign c_in    = stg[gi-1].c_reg;
            assign v_in    = stg[gi-1].v_reg;
            assign sum_raw = {slice[S-1:0], stg[gi-1].sum_reg};
`ifdef PIPE_RCA_SAT_EN
            assign sub_in  = stg[gi-1].g_fwd.sub_reg;
`endif
         end

         assign slice = {1'b0, a_in[S-1:0]} + {1'b0, b_in[S-1:0]} + {{S{1'b0}}, c_in};

         // Data registers only load for valid entries so an empty pipe keeps the last result.
         always_ff @(posedge CLK) begin
            if (RST) begin
               v_reg   <= 1'b0;
               c_reg   <= 1'b0;
               sum_reg <= '0;
            end else if (adv) begin
               v_reg <= v_in;
               if (v_in) begin
                  c_reg   <= slice[S];
                  sum_reg <= sum_next;
               end
            end
         end

         if (gi == STAGES - 1) begin : g_last
            logic c_msb;
            logic ovf_reg;

            // Carry into the MSB recovered from the MSB sum bit and its operands.
            assign c_msb = a_in[S-1] ^ b_in[S-1] ^ slice[S-1];

            always_ff @(posedge CLK) begin
               if (RST) begin
                  ovf_reg <= 1'b0;
               end else if (adv && v_in) begin
                  ovf_reg <= c_msb ^ slice[S];
               end
            end

`ifdef PIPE_RCA_SAT_EN
            always_comb begin
               sum_next = sum_raw;
               if (!sub_in && slice[S]) begin
                  sum_next = '1;
               end else if (sub_in && !slice[S]) begin
                  sum_next = '0;
               end
            end
`else
            assign sum_next = sum_raw;
`endif
         end else begin : g_fwd
            logic [REM-S-1:0] a_reg;
            logic [REM-S-1:0] b_reg;
`ifdef PIPE_RCA_SAT_EN
            logic             sub_reg;
`endif

            assign sum_next = sum_raw;

            always_ff @(posedge CLK) begin
               if (RST) begin
                  a_reg <= '0;
                  b_reg <= '0;
`ifdef PIPE_RCA_SAT_EN
                  sub_reg <= 1'b0;
`endif
               end else if (adv && v_in) begin
                  a_reg <= a_in[REM-1:S];
                  b_reg <= b_in[REM-1:S];
`ifdef PIPE_RCA_SAT_EN
                  sub_reg <= sub_in;
`endif
               end
            end
         end
      end
   endgenerate

   assign bus.OUT_VALID = out_valid;
   assign bus.SUM       = stg[STAGES-1].sum_reg;
   assign bus.COUT      = stg[STAGES-1].c_reg;
   assign bus.OVF       = stg[STAGES-1].g_last.ovf_reg;
endmodule

// File: tb/tb_pipe_rca_addsub.sv
// Self-checking bench for pipe_rca_addsub at WIDTH=8, STAGES=2 (directed table,
// back-pressure, reset mid-flight, random streaming against a reference model).
module tb_pipe_rca_addsub;
   localparam int W  = 8;
   localparam int ST = 2;
`ifdef PIPE_RCA_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   pipe_rca_addsub_if #(.WIDTH(W)) bus();

   pipe_rca_addsub #(.WIDTH(W), .STAGES(ST)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic       sub;
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference result packed as {ovf, cout, sum}.
   function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic cin, input logic sub);
      logic [8:0] r;
      logic [7:0] bb;
      logic [7:0] s;
      logic       v;
      bb = sub ? ~b : b;
      r  = {1'b0, a} + {1'b0, bb} + {8'd0, sub ? ~cin : cin};
      v  = (a[7] == bb[7]) && (r[7] != a[7]);
      s  = r[7:0];
      if (SAT && !sub && r[8]) s = 8'hFF;
      if (SAT && sub && !r[8]) s = 8'h00;
      return {v, r[8], s};
   endfunction

   task automatic run_stream(input int n, input bit rnd, input string tag);
      logic [9:0] expq[$];
      logic [9:0] exp_r;
      logic [9:0] held;
      logic [7:0] ca, cb;
      logic       cc, cs;
      bit         have = 1'b0;
      bit         stall_prev = 1'b0;
      bit         first_seen = 1'b0;
      bit         saw_block = 1'b0;
      int         stall_ctr = 0;
      int         sent = 0;
      int         got = 0;
      int         cycles = 0;
      held = '0;
      ca = '0; cb = '0; cc = 1'b0; cs = 1'b0;
      while ((sent < n || got < sent) && cycles < n * 10 + 50) begin
         if (!have && sent < n) begin
            if (rnd) begin
               ca = 8'($urandom); cb = 8'($urandom);
               cc = 1'($urandom); cs = 1'($urandom);
            end else begin
               ca = 8'(sent * 8'h31 + 8'h07); cb = 8'h5C;
               cc = sent[0]; cs = sent[1];
            end
            have = 1'b1;
         end
         bus.A = ca; bus.B = cb; bus.CIN = cc; bus.SUB = cs;
         if (rnd) begin
            bus.IN_VALID  = have && ($urandom_range(0, 9) < 7);
            bus.OUT_READY = ($urandom_range(0, 9) < 7);
         end else begin
            if (bus.OUT_VALID) first_seen = 1'b1;
            bus.IN_VALID  = have;
            bus.OUT_READY = !(first_seen && stall_ctr < 3);
            if (!bus.OUT_READY) stall_ctr++;
         end
         @(negedge CLK);
         if (stall_prev) begin
            check({tag, "_held_valid"}, bus.OUT_VALID, 1);
            check({tag, "_held_data"}, {bus.OVF, bus.COUT, bus.SUM}, held);
         end
         if (!bus.IN_READY) saw_block = 1'b1;
         if (bus.OUT_VALID && bus.OUT_READY) begin
            if (expq.size() == 0) begin
               check({tag, "_spurious_output"}, 1, 0);
            end else begin
               exp_r = expq.pop_front();
               check({tag, "_sum"},  bus.SUM,  exp_r[7:0]);
               check({tag, "_cout"}, bus.COUT, exp_r[8]);
               check({tag, "_ovf"},  bus.OVF,  exp_r[9]);
               $display("%s xfer %0d: sum=%02h cout=%0d ovf=%0d (ref %02h %0d %0d)",
                        tag, got, bus.SUM, bus.COUT, bus.OVF, exp_r[7:0], exp_r[8], exp_r[9]);
               got++;
            end
         end
         stall_prev = bus.OUT_VALID && !bus.OUT_READY;
         held = {bus.OVF, bus.COUT, bus.SUM};
         if (bus.IN_VALID && bus.IN_READY) begin
            expq.push_back(model(ca, cb, cc, cs));
            sent++;
            have = 1'b0;
         end
         @(posedge CLK); #1;
         cycles++;
      end
      bus.IN_VALID = 1'b0;
      bus.OUT_READY = 1'b1;
      check({tag, "_delivered"}, got, n);
      check({tag, "_leftover"}, expq.size(), 0);
      if (!rnd) check({tag, "_in_ready_dropped"}, saw_block, 1);
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check({tag, "_drained"}, bus.OUT_VALID, 0);
   endtask

   initial begin
      int lat;
      bit any_valid;

      vecs[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, SAT ? 8'hFF : 8'h00, 1'b1, 1'b0};
      vecs[1] = '{8'h05, 8'h07, 1'b0, 1'b1, SAT ? 8'h00 : 8'hFE, 1'b0, 1'b0};
      vecs[2] = '{8'h07, 8'h05, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
      vecs[3] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
      vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
      vecs[5] = '{8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0};
      vecs[6] = '{8'h80, 8'h80, 1'b0, 1'b0, SAT ? 8'hFF : 8'h00, 1'b1, 1'b1};
      vecs[7] = '{8'h00, 8'h00, 1'b1, 1'b1, SAT ? 8'h00 : 8'hFF, 1'b0, 1'b0};
      vecs[8] = '{8'hA5, 8'h5A, 1'b1, 1'b0, SAT ? 8'hFF : 8'h00, 1'b1, 1'b0};
      vecs[9] = '{8'h3C, 8'hC3, 1'b0, 1'b1, SAT ? 8'h00 : 8'h79, 1'b0, 1'b0};

      bus.IN_VALID = 1'b0; bus.OUT_READY = 1'b0;
      bus.A = '0; bus.B = '0; bus.CIN = 1'b0; bus.SUB = 1'b0;
      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;
      @(negedge CLK);
      check("rst_out_valid", bus.OUT_VALID, 0);
      check("rst_sum", bus.SUM, 0);
      check("rst_cout", bus.COUT, 0);
      check("rst_ovf", bus.OVF, 0);
      check("rst_in_ready", bus.IN_READY, 1);

      // Directed table, one operation at a time with latency check.
      for (int i = 0; i < 10; i++) begin
         @(posedge CLK); #1;
         bus.A = vecs[i].a; bus.B = vecs[i].b;
         bus.CIN = vecs[i].cin; bus.SUB = vecs[i].sub;
         bus.IN_VALID = 1'b1; bus.OUT_READY = 1'b1;
         @(negedge CLK);
         check("vec_in_ready", bus.IN_READY, 1);
         @(posedge CLK); #1;
         bus.IN_VALID = 1'b0;
         lat = 0;
         while (!bus.OUT_VALID && lat < 8) begin
            @(posedge CLK); #1;
            lat++;
         end
         check("vec_latency", lat, ST - 1);
         check("vec_sum", bus.SUM, vecs[i].sum);
         check("vec_cout", bus.COUT, vecs[i].cout);
         check("vec_ovf", bus.OVF, vecs[i].ovf);
         $display("vec %0d: %02h %s %02h c%0d -> sum=%02h cout=%0d ovf=%0d (ref %02h %0d %0d)",
                  i, vecs[i].a, vecs[i].sub ? "-" : "+", vecs[i].b, vecs[i].cin,
                  bus.SUM, bus.COUT, bus.OVF, vecs[i].sum, vecs[i].cout, vecs[i].ovf);
      end

      // Reset with two entries in flight: neither may ever be delivered.
      @(posedge CLK); #1;
      bus.A = 8'h12; bus.B = 8'h34; bus.CIN = 1'b0; bus.SUB = 1'b0;
      bus.IN_VALID = 1'b1; bus.OUT_READY = 1'b0;
      @(posedge CLK); #1;
      bus.A = 8'h56; bus.B = 8'h21;
      @(posedge CLK); #1;
      check("mid_full_valid", bus.OUT_VALID, 1);
      check("mid_full_in_ready", bus.IN_READY, 0);
      RST = 1'b1; bus.IN_VALID = 1'b0;
      @(posedge CLK); #1;
      check("mid_rst_out_valid", bus.OUT_VALID, 0);
      check("mid_rst_sum", bus.SUM, 0);
      check("mid_rst_cout", bus.COUT, 0);
      check("mid_rst_ovf", bus.OVF, 0);
      check("mid_rst_in_ready", bus.IN_READY, 1);
      $display("reset mid-flight: out_valid=%0d sum=%02h in_ready=%0d",
               bus.OUT_VALID, bus.SUM, bus.IN_READY);
      RST = 1'b0; bus.OUT_READY = 1'b1;
      any_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         if (bus.OUT_VALID) any_valid = 1'b1;
      end
      check("mid_rst_no_ghost", any_valid, 0);
      @(posedge CLK); #1;

      run_stream(4, 1'b0, "bp");
      @(posedge CLK); #1;
      run_stream(1000, 1'b1, "rnd");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
